// File: rtl/alu_issue.sv
// ID/EX issue stage of the miniRV pipeline: decodes the ID instruction into an
// ALU op and operands, forwards from MEM/WB, detects load-use and registers EX.
module alu_issue #(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_inst,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_fwd_we,
  input  logic [4:0]      mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_we,
  input  logic [4:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            id_stall_req,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_alu_a,
  output logic [XLEN-1:0] ex_alu_b,
  output logic [3:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rd,
  output logic            ex_rf_we,
  output logic [1:0]      ex_wb_sel,
  output logic            ex_mem_re,
  output logic            ex_mem_we,
  output logic            ex_is_branch,
  output logic            ex_is_jump,
  output logic [XLEN-1:0] ex_br_tgt,
  output logic [XLEN-1:0] ex_pc4
);

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0010;
  localparam logic [3:0] ALU_BGEU = 4'b0011;
  localparam logic [3:0] ALU_BEQ  = 4'b0100;
  localparam logic [3:0] ALU_BNE  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_BGE  = 4'b0111;
  localparam logic [3:0] ALU_AND  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic            rf_we;
    logic [1:0]      wb_sel;
    logic            mem_re;
    logic            mem_we;
    logic            is_branch;
    logic            is_jump;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] pc4;
  } ex_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Shared by R-type and I-ALU; only R-type honours the SUB alternate.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                          input logic is_reg);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic            alt_s;
  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [4:0]      rd_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_st_s;
  logic [XLEN-1:0] imm_b_s;
  logic [XLEN-1:0] imm_u_s;
  logic [XLEN-1:0] imm_j_s;

  assign opcode_s = id_inst[6:0];
  assign rd_s     = id_inst[11:7];
  assign funct3_s = id_inst[14:12];
  assign rs1_s    = id_inst[19:15];
  assign rs2_s    = id_inst[24:20];
  assign alt_s    = id_inst[30];

  assign imm_i_s  = sext32({{20{id_inst[31]}}, id_inst[31:20]});
  assign imm_st_s = sext32({{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]});
  assign imm_b_s  = sext32({{19{id_inst[31]}}, id_inst[31], id_inst[7],
                            id_inst[30:25], id_inst[11:8], 1'b0});
  assign imm_u_s  = sext32({id_inst[31:12], 12'h000});
  assign imm_j_s  = sext32({{11{id_inst[31]}}, id_inst[31], id_inst[19:12],
                            id_inst[20], id_inst[30:21], 1'b0});

  logic            mem_hit1_s;
  logic            wb_hit1_s;
  logic            mem_hit2_s;
  logic            wb_hit2_s;
  logic [XLEN-1:0] rs1_fwd_s;
  logic [XLEN-1:0] rs2_fwd_s;

  assign mem_hit1_s = FWD_EN && mem_fwd_we && (mem_fwd_rd == rs1_s) && (rs1_s != 5'd0);
  assign wb_hit1_s  = FWD_EN && wb_fwd_we  && (wb_fwd_rd  == rs1_s) && (rs1_s != 5'd0);
  assign mem_hit2_s = FWD_EN && mem_fwd_we && (mem_fwd_rd == rs2_s) && (rs2_s != 5'd0);
  assign wb_hit2_s  = FWD_EN && wb_fwd_we  && (wb_fwd_rd  == rs2_s) && (rs2_s != 5'd0);

  // Operand forwarding: the younger MEM result wins over WB.
  always_comb begin
    rs1_fwd_s = id_rs1_data;
    rs2_fwd_s = id_rs2_data;
    if (mem_hit1_s) begin
      rs1_fwd_s = mem_fwd_data;
    end else if (wb_hit1_s) begin
      rs1_fwd_s = wb_fwd_data;
    end else begin
      rs1_fwd_s = id_rs1_data;
    end
    if (mem_hit2_s) begin
      rs2_fwd_s = mem_fwd_data;
    end else if (wb_hit2_s) begin
      rs2_fwd_s = wb_fwd_data;
    end else begin
      rs2_fwd_s = id_rs2_data;
    end
  end

  ex_t  dec_s;
  logic known_s;
  logic use_rs1_s;
  logic use_rs2_s;

  // Instruction decode into the EX payload; unknown encodings become a bubble.
  always_comb begin
    dec_s          = '0;
    known_s        = 1'b1;
    use_rs1_s      = 1'b0;
    use_rs2_s      = 1'b0;
    dec_s.rs2_data = rs2_fwd_s;
    dec_s.br_tgt   = id_pc + imm_b_s;
    dec_s.pc4      = id_pc + PC_STEP;
    case (opcode_s)
      OPC_R: begin
        dec_s.alu_a  = rs1_fwd_s;
        dec_s.alu_b  = rs2_fwd_s;
        dec_s.alu_op = arith_op(funct3_s, alt_s, 1'b1);
        dec_s.rd     = rd_s;
        dec_s.rf_we  = 1'b1;
        use_rs1_s    = 1'b1;
        use_rs2_s    = 1'b1;
      end
      OPC_I: begin
        dec_s.alu_a  = rs1_fwd_s;
        dec_s.alu_b  = imm_i_s;
        dec_s.alu_op = arith_op(funct3_s, alt_s, 1'b0);
        dec_s.rd     = rd_s;
        dec_s.rf_we  = 1'b1;
        use_rs1_s    = 1'b1;
      end
      OPC_LW: begin
        dec_s.alu_a  = rs1_fwd_s;
        dec_s.alu_b  = imm_i_s;
        dec_s.rd     = rd_s;
        dec_s.rf_we  = 1'b1;
        dec_s.wb_sel = WB_MEM;
        dec_s.mem_re = 1'b1;
        use_rs1_s    = 1'b1;
      end
      OPC_SW: begin
        dec_s.alu_a  = rs1_fwd_s;
        dec_s.alu_b  = imm_st_s;
        dec_s.mem_we = 1'b1;
        use_rs1_s    = 1'b1;
        use_rs2_s    = 1'b1;
      end
      OPC_BR: begin
        dec_s.alu_a     = rs1_fwd_s;
        dec_s.alu_b     = rs2_fwd_s;
        dec_s.is_branch = 1'b1;
        use_rs1_s       = 1'b1;
        use_rs2_s       = 1'b1;
        case (funct3_s)
          3'b000:  dec_s.alu_op = ALU_BEQ;
          3'b001:  dec_s.alu_op = ALU_BNE;
          3'b100:  dec_s.alu_op = ALU_SLT;
          3'b101:  dec_s.alu_op = ALU_BGE;
          3'b110:  dec_s.alu_op = ALU_SLTU;
          3'b111:  dec_s.alu_op = ALU_BGEU;
          default: known_s      = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_s.alu_b = imm_u_s;
        dec_s.rd    = rd_s;
        dec_s.rf_we = 1'b1;
      end
      OPC_JAL: begin
        dec_s.alu_a   = id_pc;
        dec_s.alu_b   = imm_j_s;
        dec_s.rd      = rd_s;
        dec_s.rf_we   = 1'b1;
        dec_s.wb_sel  = WB_PC4;
        dec_s.is_jump = 1'b1;
      end
      OPC_JALR: begin
        dec_s.alu_a   = rs1_fwd_s;
        dec_s.alu_b   = imm_i_s;
        dec_s.rd      = rd_s;
        dec_s.rf_we   = 1'b1;
        dec_s.wb_sel  = WB_PC4;
        dec_s.is_jump = 1'b1;
        use_rs1_s     = 1'b1;
      end
      default: begin
        known_s = 1'b0;
      end
    endcase
    if (id_valid && known_s) begin
      dec_s.valid = 1'b1;
    end else begin
      dec_s     = '0;
      use_rs1_s = 1'b0;
      use_rs2_s = 1'b0;
    end
  end

  ex_t  ex_q;
  ex_t  ex_d;
  logic hazard_s;

  assign hazard_s = id_valid && ex_q.valid && ex_q.mem_re && (ex_q.rd != 5'd0) &&
                    ((use_rs1_s && (ex_q.rd == rs1_s)) || (use_rs2_s && (ex_q.rd == rs2_s)));
  assign id_stall_req = hazard_s && !stall;

  // EX next state: a downstream stall freezes the slot, even over a flush.
  always_comb begin
    ex_d = ex_q;
    if (stall) begin
      ex_d = ex_q;
    end else if (flush || id_stall_req) begin
      ex_d = '0;
    end else begin
      ex_d = dec_s;
    end
  end

  // EX pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_alu_a     = ex_q.alu_a;
  assign ex_alu_b     = ex_q.alu_b;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_rd        = ex_q.rd;
  assign ex_rf_we     = ex_q.rf_we;
  assign ex_wb_sel    = ex_q.wb_sel;
  assign ex_mem_re    = ex_q.mem_re;
  assign ex_mem_we    = ex_q.mem_we;
  assign ex_is_branch = ex_q.is_branch;
  assign ex_is_jump   = ex_q.is_jump;
  assign ex_br_tgt    = ex_q.br_tgt;
  assign ex_pc4       = ex_q.pc4;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: instructions are described at the mnemonic
// level, encoded, and the expected EX contents are derived from the description.
module tb_alu_issue;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4;
  localparam int K_LUI = 5, K_JAL = 6, K_JALR = 7, K_BAD = 8;

  logic        clk, rst, id_valid, stall, flush, mem_fwd_we, wb_fwd_we;
  logic [31:0] id_inst, id_pc, id_rs1_data, id_rs2_data, mem_fwd_data, wb_fwd_data;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic        id_stall_req, ex_valid, ex_rf_we, ex_mem_re, ex_mem_we, ex_is_branch, ex_is_jump;
  logic [31:0] ex_alu_a, ex_alu_b, ex_rs2_data, ex_br_tgt, ex_pc4;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb_sel;

  alu_issue #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .stall(stall), .flush(flush),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .id_stall_req(id_stall_req), .ex_valid(ex_valid), .ex_alu_a(ex_alu_a),
    .ex_alu_b(ex_alu_b), .ex_alu_op(ex_alu_op), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_rf_we(ex_rf_we), .ex_wb_sel(ex_wb_sel), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_br_tgt(ex_br_tgt), .ex_pc4(ex_pc4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] rs2d;
    logic [4:0]  rd;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        mem_re;
    logic        mem_we;
    logic        br;
    logic        jmp;
    logic [31:0] br_tgt;
    logic [31:0] pc4;
  } exp_t;

  typedef struct {
    int          kind;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } desc_t;

  typedef struct {
    logic sreq;
    exp_t ex;
    int   n;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    n_issued = 0;
  exp_t  cur = '0;
  desc_t d;

  function automatic desc_t mk(input int kind, input logic [2:0] f3, input logic alt,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] imm);
    desc_t x;
    x.kind = kind; x.f3 = f3; x.alt = alt; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.imm = imm;
    return x;
  endfunction

  function automatic logic [31:0] encode(input desc_t x);
    logic [31:0] i;
    i = x.imm;
    case (x.kind)
      K_R:    return {1'b0, x.alt, 5'b0, x.rs2, x.rs1, x.f3, x.rd, 7'b0110011};
      K_I:    return {i[11:0], x.rs1, x.f3, x.rd, 7'b0010011};
      K_LW:   return {i[11:0], x.rs1, 3'b010, x.rd, 7'b0000011};
      K_SW:   return {i[11:5], x.rs2, x.rs1, 3'b010, i[4:0], 7'b0100011};
      K_BR:   return {i[12], i[10:5], x.rs2, x.rs1, x.f3, i[4:1], i[11], 7'b1100011};
      K_LUI:  return {i[31:12], x.rd, 7'b0110111};
      K_JAL:  return {i[20], i[10:1], i[11], i[19:12], x.rd, 7'b1101111};
      K_JALR: return {i[11:0], x.rs1, 3'b000, x.rd, 7'b1100111};
      default: return {i[24:0], 7'b1111111};
    endcase
  endfunction

  // Op code table by mnemonic.
  function automatic logic [3:0] alu_code(input desc_t x);
    logic [3:0] r;
    r = 4'b0000;
    if (x.kind == K_BR) begin
      case (x.f3)
        3'd0: r = 4'b0100;  3'd1: r = 4'b0101;  3'd4: r = 4'b0110;
        3'd5: r = 4'b0111;  3'd6: r = 4'b0010;  default: r = 4'b0011;
      endcase
    end else if (x.kind == K_R || x.kind == K_I) begin
      case (x.f3)
        3'd0: r = (x.kind == K_R && x.alt) ? 4'b0001 : 4'b0000;
        3'd1: r = 4'b1100;  3'd2: r = 4'b0110;  3'd3: r = 4'b0010;
        3'd4: r = 4'b1010;  3'd5: r = x.alt ? 4'b1110 : 4'b1101;
        3'd6: r = 4'b1001;  default: r = 4'b1000;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs != 0 && mem_fwd_we && mem_fwd_rd == rs) return mem_fwd_data;
    if (rs != 0 && wb_fwd_we && wb_fwd_rd == rs) return wb_fwd_data;
    return rf;
  endfunction

  function automatic logic reads_reg(input desc_t x, input logic [4:0] r);
    case (x.kind)
      K_R, K_SW, K_BR:   return (x.rs1 == r) || (x.rs2 == r);
      K_I, K_LW, K_JALR: return x.rs1 == r;
      default:           return 1'b0;
    endcase
  endfunction

  function automatic exp_t model_issue(input desc_t x);
    exp_t        e;
    logic [31:0] v1, bimm;
    e = '0;
    if (!id_valid || x.kind == K_BAD) return e;
    v1 = fwd(x.rs1, id_rs1_data);
    bimm = {{19{id_inst[31]}}, id_inst[31], id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
    e.valid  = 1'b1;
    e.op     = alu_code(x);
    e.rs2d   = fwd(id_inst[24:20], id_rs2_data);
    e.pc4    = id_pc + 32'd4;
    e.br_tgt = (x.kind == K_BR) ? id_pc + x.imm : id_pc + bimm;
    e.a      = v1;
    e.b      = x.imm;
    e.rd     = x.rd;
    e.rf_we  = 1'b1;
    case (x.kind)
      K_R:    e.b = fwd(x.rs2, id_rs2_data);
      K_LW:   begin e.mem_re = 1'b1; e.wb_sel = 2'b01; end
      K_SW:   begin e.mem_we = 1'b1; e.rf_we = 1'b0; e.rd = 5'd0; end
      K_BR:   begin e.b = fwd(x.rs2, id_rs2_data); e.br = 1'b1; e.rf_we = 1'b0; e.rd = 5'd0; end
      K_LUI:  e.a = 32'd0;
      K_JAL:  begin e.a = id_pc; e.wb_sel = 2'b10; e.jmp = 1'b1; end
      K_JALR: begin e.wb_sel = 2'b10; e.jmp = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic desc_t gen_desc();
    desc_t       x;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [2:0]  bf3 [6];
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    i12 = 12'($urandom);
    b13 = 13'($urandom);
    b13[0] = 1'b0;
    j21 = 21'($urandom);
    j21[0] = 1'b0;
    x = mk(int'($urandom % 9), 3'($urandom), 1'b0, 5'($urandom % 8), 5'($urandom % 8),
           5'($urandom % 8), {{20{i12[11]}}, i12});
    case (x.kind)
      K_R:   x.alt = (x.f3 == 3'd0 || x.f3 == 3'd5) ? 1'($urandom) : 1'b0;
      K_I: begin
        if (x.f3 == 3'd1) x.imm = {27'd0, i12[4:0]};
        if (x.f3 == 3'd5) begin
          x.alt = 1'($urandom);
          x.imm = {21'd0, x.alt, 5'd0, i12[4:0]};
        end
      end
      K_BR:  x.imm = {{19{b13[12]}}, b13};
      K_LUI: x.imm = {$urandom, 12'h000} >> 12 << 12;
      K_JAL: x.imm = {{11{j21[20]}}, j21};
      default: ;
    endcase
    if (x.kind == K_BR) x.f3 = bf3[$urandom % 6];
    return x;
  endfunction

  // Encodes the current descriptor, predicts the DUT response, queues it and
  // advances to just after the next clock edge.
  task automatic step();
    item_t it;
    exp_t  nxt;
    logic  sreq;
    id_inst = encode(d);
    sreq = !stall && id_valid && cur.valid && cur.mem_re && cur.rd != 0 && reads_reg(d, cur.rd);
    if (rst) nxt = '0;
    else if (stall) nxt = cur;
    else if (flush || sreq) nxt = '0;
    else nxt = model_issue(d);
    cur     = nxt;
    it.sreq = sreq;
    it.ex   = nxt;
    it.n    = n_issued;
    n_issued++;
    sb.push_back(it);
    @(posedge clk);
    #2;
  endtask

  task automatic quiet_fwd();
    mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
  endtask

  initial begin : monitor
    item_t it;
    exp_t  act;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        checks++;
        if (id_stall_req !== it.sreq) begin
          errors++;
          $display("FAIL stall_req #%0d: got %b expected %b", it.n, id_stall_req, it.sreq);
        end
        @(posedge clk);
        #1;
        act = {ex_valid, ex_alu_a, ex_alu_b, ex_alu_op, ex_rs2_data, ex_rd, ex_rf_we, ex_wb_sel,
               ex_mem_re, ex_mem_we, ex_is_branch, ex_is_jump, ex_br_tgt, ex_pc4};
        checks++;
        if (act !== it.ex) begin
          errors++;
          $display("FAIL ex_state #%0d: got %h expected %h", it.n, act, it.ex);
        end
      end
    end
  end

  initial begin : stim
    rst = 1; stall = 0; flush = 0; id_valid = 0; id_pc = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_inst = 0;
    quiet_fwd();
    d = mk(K_BAD, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    step();
    rst = 0; id_valid = 1;
    // add x3,x1,x2
    id_rs1_data = 5; id_rs2_data = 7; id_pc = 32'h40;
    d = mk(K_R, 0, 0, 1, 2, 3, 0); step();
    // blt / bge / bgeu x1,x2,-8 at 0x100
    id_pc = 32'h100;
    d = mk(K_BR, 4, 0, 1, 2, 0, -32'sd8); step();
    d.f3 = 5; step();
    d.f3 = 7; step();
    // addi x7,x4,0 under forwarding variants
    d = mk(K_I, 0, 0, 4, 0, 7, 0); id_rs1_data = 32'h11;
    mem_fwd_we = 1; mem_fwd_rd = 4; mem_fwd_data = 32'hAA;
    wb_fwd_we = 1; wb_fwd_rd = 4; wb_fwd_data = 32'hBB; step();
    mem_fwd_we = 0; step();
    d.rs1 = 0; id_rs1_data = 0; wb_fwd_we = 0;
    mem_fwd_we = 1; mem_fwd_rd = 0; mem_fwd_data = 32'hDEAD; step();
    quiet_fwd();
    // lw x5,0(x1); addi x6,x5,1 stalls once then issues
    d = mk(K_LW, 2, 0, 1, 0, 5, 0); step();
    d = mk(K_I, 0, 0, 5, 0, 6, 1); step(); step();
    d = mk(K_LW, 2, 0, 1, 0, 5, 0); step();
    d = mk(K_LUI, 0, 0, 0, 0, 5, 32'h12345000); step();
    // stall with a flush in the middle, then flush after release
    d = mk(K_R, 0, 1, 1, 2, 9, 0); step();
    stall = 1; step();
    flush = 1; step();
    flush = 0; step();
    stall = 0; flush = 1; step();
    flush = 0; step();
    stall = 1; step();
    rst = 1; step();
    rst = 0; stall = 0; step();
    // pc + 4 and branch target wrap-around
    id_pc = 32'hFFFF_FFFC; d = mk(K_BR, 0, 0, 1, 2, 0, 32'd16); step();
    for (int n = 0; n < 3000; n++) begin
      d           = gen_desc();
      rst         = ($urandom % 60) == 0;
      stall       = ($urandom % 8) == 0;
      flush       = ($urandom % 10) == 0;
      id_valid    = ($urandom % 8) != 0;
      id_pc       = (($urandom % 8) == 0) ? 32'hFFFF_FFF0 + 4 * ($urandom % 4) : $urandom & 32'hFFFF_FFFC;
      id_rs1_data = $urandom; id_rs2_data = $urandom;
      mem_fwd_we  = 1'($urandom); mem_fwd_rd = 5'($urandom % 8); mem_fwd_data = $urandom;
      wb_fwd_we   = 1'($urandom); wb_fwd_rd = 5'($urandom % 8); wb_fwd_data = $urandom;
      step();
    end
    rst = 0; stall = 0; flush = 0; id_valid = 0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #4;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d items left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- ID/EX issue stage of the miniRV pipeline, on the sending side of the ALU interface.
- Decodes the instruction in ID into the 4-bit ALU op code, resolves the A and B operands, and registers everything into the EX stage.
- Resolves operands with MEM- and WB-stage forwarding.
- Detects load-use hazards, inserting a bubble and requesting an ID stall.

Parameters:
- XLEN, 32, datapath width.
- FWD_EN, 1, 1 enables forwarding muxes; 0 passes register-file data straight through.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_inst  in  32  instruction word.
- id_pc  in  XLEN  PC of id_inst.
- id_rs1_data  in  XLEN  register-file rs1 read data.
- id_rs2_data  in  XLEN  register-file rs2 read data.
- stall  in  1  hold EX register; downstream is stalled.
- flush  in  1  kill the instruction entering EX (taken branch/jump).
- mem_fwd_we  in  1  MEM-stage writeback enable.
- mem_fwd_rd  in  5  MEM-stage destination register.
- mem_fwd_data  in  XLEN  MEM-stage result.
- wb_fwd_we  in  1  WB-stage writeback enable.
- wb_fwd_rd  in  5  WB-stage destination register.
- wb_fwd_data  in  XLEN  WB-stage result.
- id_stall_req  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  EX slot holds a live instruction.
- ex_alu_a  out  XLEN  ALU operand A.
- ex_alu_b  out  XLEN  ALU operand B.
- ex_alu_op  out  4  ALU op code.
- ex_rs2_data  out  XLEN  forwarded rs2, used as store data.
- ex_rd  out  5  destination register.
- ex_rf_we  out  1  register write enable.
- ex_wb_sel  out  2  writeback source: 00 ALU, 01 memory, 10 pc+4.
- ex_mem_re  out  1  load.
- ex_mem_we  out  1  store.
- ex_is_branch  out  1  conditional branch; taken is indicated by the ALU flag.
- ex_is_jump  out  1  jal/jalr; ALU C is the jump target.
- ex_br_tgt  out  XLEN  pc + imm_b.
- ex_pc4  out  XLEN  pc + 4.

Behaviour:
- ALU op encoding:
  - ADD 0000, SUB 0001.
  - SLTU/BLTU 0010, BGEU 0011.
  - BEQ 0100, BNE 0101.
  - SLT/BLT 0110, BGE 0111.
  - AND 1000, OR 1001, XOR 1010.
  - SLL 1100, SRL 1101, SRA 1110.
- Decode:
  - R-type (opcode 0110011): A=rs1, B=rs2. op from funct3 plus funct7[5] (sub, sra).
  - I-ALU (0010011): A=rs1, B=sign-extended imm_i. Shifts pass the imm unmodified; the ALU uses only B[4:0].
  - lw (0000011): op ADD, A=rs1, B=imm_i, mem_re=1, wb_sel=01.
  - sw (0100011): op ADD, A=rs1, B=imm_s, mem_we=1, rf_we=0.
  - branch (1100011): A=rs1, B=rs2, op per funct3 (000→0100, 001→0101, 100→0110, 101→0111, 110→0010, 111→0011), rf_we=0.
  - lui (0110111): A=0, B=imm_u, op ADD.
  - jal (1101111): A=pc, B=imm_j, op ADD, wb_sel=10, is_jump=1.
  - jalr (1100111): A=rs1, B=imm_i, op ADD, wb_sel=10, is_jump=1.
  - Unknown opcode decodes as a bubble.
- Forwarding, evaluated separately for rs1 and rs2:
  - The MEM stage matches if mem_fwd_we and mem_fwd_rd==rs and rs≠0.
  - Else the WB stage matches under the same rule with the wb_fwd_* signals.
  - Else register-file data is used.
  - MEM wins when both MEM and WB match.
- Load-use hazard:
  - id_stall_req = id_valid & ex_valid & ex_mem_re & ex_rd≠0 & (ex_rd==rs1 used | ex_rd==rs2 used).
  - "Used" follows the decode: lui and jal use neither register; I-type, lw and jalr use rs1 only.
  - id_stall_req is forced to 0 while stall=1.
- EX register update priority at each posedge:
  1. rst: all outputs 0, ex_valid=0.
  2. stall: hold all outputs, including during flush; flush is applied on the first non-stalled cycle only if still asserted.
  3. flush: bubble.
  4. id_stall_req: bubble.
  5. Otherwise load the decoded ID instruction; ex_valid=id_valid.
- A bubble means ex_valid=0 and rf_we, mem_re, mem_we, is_branch, is_jump all 0; datapath fields are don't-care but driven to 0.
- Latency: one cycle from ID to the EX outputs.
- ex_br_tgt = pc+imm_b and ex_pc4 = pc+4 are computed in ID, modulo 2^XLEN; wrap-around is allowed.
- A reset asserted mid-stall or mid-flush still clears everything on that edge.

Test Plan:
- add x3,x1,x2 with rs1=5, rs2=7, no hazards → next cycle ex_alu_op=0000, A=5, B=7, rd=3, rf_we=1, ex_valid=1.
- blt x1,x2,-8 at pc=0x100 → op=0110, is_branch=1, rf_we=0, ex_br_tgt=0xF8; bge gives 0111, bgeu gives 0011.
- Forwarding of rs1=x4:
  - MEM writing x4=0xAA and WB writing x4=0xBB → A=0xAA.
  - WB only → A=0xBB.
  - rs1=x0 with mem_fwd_rd=0 → A=register-file value (0).
- lw x5,0(x1) followed by addi x6,x5,1:
  - id_stall_req=1 for one cycle, then EX shows a bubble (ex_valid=0).
  - Next cycle the addi issues with B=1.
  - lui x5 in place of the addi → no stall.
- stall=1 for 3 cycles with flush=1 in the 2nd → EX outputs unchanged through all three cycles.
- After the stall releases, flush=1 → bubble; rst=1 mid-stall → all outputs 0 on the next edge.
